// File: rtl/matrix_port_arbiter.sv
// Two-requester arbiter in front of one BRAM port: round-robin when idle,
// with optional locked bursts that are capped in length and released after an idle timeout.
module matrix_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_q
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [BW:0] MAX_B = (BW + 1)'(MAX_BURST);
    localparam logic [IW:0] TO_C  = (IW + 1)'(TIMEOUT);

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            r0_rvalid_q, r1_rvalid_q;
    logic            win0, win1, lock_w;
    logic [BW:0]     beats_inc;
    logic [IW:0]     idle_inc;

    assign beats_inc = {1'b0, beats_q} + {{BW{1'b0}}, 1'b1};
    assign idle_inc  = {1'b0, idle_q} + {{IW{1'b0}}, 1'b1};

    // Grants are gated by reset so nothing reaches the BRAM while it is held.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (r0_req && r1_req) begin
                        win0 = ~rr_ptr_q;
                        win1 = rr_ptr_q;
                    end else begin
                        win0 = r0_req;
                        win1 = r1_req;
                    end
                end
                OWN0:    win0 = r0_req;
                OWN1:    win1 = r1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        beats_d  = beats_q;
        idle_d   = idle_q;
        lock_w   = win0 ? r0_lock : r1_lock;
        if (win0 || win1) begin
            if (lock_w && (beats_inc < MAX_B)) begin
                state_d = win0 ? OWN0 : OWN1;
                beats_d = beats_inc[BW-1:0];
                idle_d  = '0;
            end else begin
                state_d  = IDLE;
                beats_d  = '0;
                idle_d   = '0;
                rr_ptr_d = win0;
            end
        end else if (state_q != IDLE) begin
            // Owner went quiet: release after TIMEOUT empty cycles, handing priority over.
            if (idle_inc >= TO_C) begin
                state_d  = IDLE;
                beats_d  = '0;
                idle_d   = '0;
                rr_ptr_d = (state_q == OWN0);
            end else begin
                idle_d = idle_inc[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            beats_q     <= '0;
            idle_q      <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beats_q     <= beats_d;
            idle_q      <= idle_d;
            r0_rvalid_q <= win0;
            r1_rvalid_q <= win1 & ~r1_we;
        end
    end

    assign r0_gnt    = win0;
    assign r1_gnt    = win1;
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = bram_q;
    assign r1_rdata  = bram_q;
    assign bram_addr = win0 ? r0_addr : (win1 ? r1_addr : '0);
    assign bram_we   = win1 & r1_we;
    assign bram_data = win1 ? r1_wdata : '0;

endmodule
